// File: rtl/cascaded_alu_pkg.sv
// Shared types and width helpers for the sequenced cascaded ALU.
package cascaded_alu_pkg;

  localparam int OP_W = 3;

  typedef enum logic [2:0] {
    OP_MUL  = 3'b000,
    OP_ADD  = 3'b001,
    OP_SUB  = 3'b010,
    OP_ADD1 = 3'b011,
    OP_OR   = 3'b100,
    OP_AND  = 3'b101,
    OP_XOR  = 3'b110,
    OP_NOT  = 3'b111
  } alu_op_t;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_EXEC     = 2'd1,
    S_MUL_WAIT = 2'd2
  } seq_state_t;

  // Index width that stays at least one bit even for a single-entry range.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cascaded_alu_seq_alu_step_core.sv
// Combinational ALU for one chain step; all results are RESULT_WIDTH wide.
module alu_step_core
  import cascaded_alu_pkg::*;
#(
  parameter int DATA_WIDTH   = 16,
  parameter int RESULT_WIDTH = 2 * DATA_WIDTH
) (
  input  logic [DATA_WIDTH-1:0]   a_i,
  input  logic [DATA_WIDTH-1:0]   b_i,
  input  alu_op_t                 op_i,
  output logic [RESULT_WIDTH-1:0] res_o
);

  logic [RESULT_WIDTH-1:0] za;
  logic [RESULT_WIDTH-1:0] zb;

  assign za = RESULT_WIDTH'(a_i);
  assign zb = RESULT_WIDTH'(b_i);

  // Operand zero-extension first, so carries and borrows land in the upper half.
  always_comb begin
    res_o = '0;
    case (op_i)
      OP_MUL:  res_o = za * zb;
      OP_ADD:  res_o = za + zb;
      OP_SUB:  res_o = za - zb;
      OP_ADD1: res_o = za + zb + RESULT_WIDTH'(1);
      OP_OR:   res_o = za | zb;
      OP_AND:  res_o = za & zb;
      OP_XOR:  res_o = za ^ zb;
      OP_NOT:  res_o = {~a_i, ~b_i};
      default: res_o = '0;
    endcase
  end

endmodule

// File: rtl/cascaded_alu_seq.sv
// Sequencer running a chain of ALU steps on a shared datapath; each result
// is fed back as {A,B} for the next step.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | waiting for start_op; num_ops=0 completes straight from here
// S_EXEC     | executes the current step; non-MUL steps write acc here
// S_MUL_WAIT | multiply in progress; acc held, countdown to product write
module cascaded_alu_seq
  import cascaded_alu_pkg::*;
#(
  parameter int DATA_WIDTH   = 16,
  parameter int RESULT_WIDTH = 2 * DATA_WIDTH,
  parameter int MAX_OPS      = 4,
  parameter int MUL_LATENCY  = 3
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [DATA_WIDTH-1:0]             A,
  input  logic [DATA_WIDTH-1:0]             B,
  input  logic [OP_W*MAX_OPS-1:0]           ops,
  input  logic [$clog2(MAX_OPS+1)-1:0]      num_ops,
  input  logic                              start_op,
  output logic                              busy,
  output logic                              end_op,
  output logic [RESULT_WIDTH-1:0]           result
);

  localparam int NW = $clog2(MAX_OPS + 1);
  localparam int SW = idx_w(MAX_OPS);
  localparam int CW = idx_w(MUL_LATENCY + 1);

  seq_state_t                state_q, state_d;
  logic [SW-1:0]             step_q, step_d;
  logic [SW-1:0]             last_q, last_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [RESULT_WIDTH-1:0]   acc_q, acc_d;
  logic [OP_W*MAX_OPS-1:0]   ops_q, ops_d;
  logic                      busy_q, busy_d;
  logic                      end_op_q, end_op_d;
  logic [RESULT_WIDTH-1:0]   result_q, result_d;

  logic [NW-1:0]             nsat;
  alu_op_t                   cur_op;
  logic [RESULT_WIDTH-1:0]   alu_res;
  logic                      wr;

  // Requests longer than the chain capacity run the full capacity.
  assign nsat   = (num_ops > NW'(MAX_OPS)) ? NW'(MAX_OPS) : num_ops;
  assign cur_op = alu_op_t'(ops_q[OP_W*step_q +: OP_W]);

  alu_step_core #(
    .DATA_WIDTH   (DATA_WIDTH),
    .RESULT_WIDTH (RESULT_WIDTH)
  ) u_alu (
    .a_i   (acc_q[RESULT_WIDTH-1:DATA_WIDTH]),
    .b_i   (acc_q[DATA_WIDTH-1:0]),
    .op_i  (cur_op),
    .res_o (alu_res)
  );

  // Next-state, step/countdown control and completion handling.
  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    ops_d    = ops_q;
    busy_d   = busy_q;
    end_op_d = 1'b0;
    result_d = result_q;
    wr       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_op) begin
          ops_d = ops;
          acc_d = {A, B};
          if (nsat == '0) begin
            result_d = {A, B};
            end_op_d = 1'b1;
          end else begin
            state_d = S_EXEC;
            busy_d  = 1'b1;
            step_d  = '0;
            last_d  = SW'(nsat - NW'(1));
          end
        end
      end
      S_EXEC: begin
        if (cur_op == OP_MUL && MUL_LATENCY > 1) begin
          state_d = S_MUL_WAIT;
          cnt_d   = CW'(MUL_LATENCY - 1);
        end else begin
          wr = 1'b1;
        end
      end
      S_MUL_WAIT: begin
        // The edge that brings the countdown to zero is the product write.
        if (cnt_q <= CW'(1)) begin
          cnt_d = '0;
          wr    = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (wr) begin
      acc_d = alu_res;
      if (step_q == last_q) begin
        result_d = alu_res;
        end_op_d = 1'b1;
        busy_d   = 1'b0;
        state_d  = S_IDLE;
        step_d   = '0;
      end else begin
        step_d  = step_q + SW'(1);
        state_d = S_EXEC;
      end
    end
  end

  // State and output registers; reset aborts any chain in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      step_q   <= '0;
      last_q   <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      ops_q    <= '0;
      busy_q   <= 1'b0;
      end_op_q <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      ops_q    <= ops_d;
      busy_q   <= busy_d;
      end_op_q <= end_op_d;
      result_q <= result_d;
    end
  end

  assign busy   = busy_q;
  assign end_op = end_op_q;
  assign result = result_q;

endmodule

// File: tb/tb_cascaded_alu_seq.sv
// Directed bench for cascaded_alu_seq (DATA_WIDTH=16, MAX_OPS=4, MUL_LATENCY=3).
module tb_cascaded_alu_seq;

  logic        clk;
  logic        rst_n;
  logic [15:0] A;
  logic [15:0] B;
  logic [11:0] ops;
  logic [2:0]  num_ops;
  logic        start_op;
  logic        busy;
  logic        end_op;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  cascaded_alu_seq #(
    .DATA_WIDTH   (16),
    .RESULT_WIDTH (32),
    .MAX_OPS      (4),
    .MUL_LATENCY  (3)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .A        (A),
    .B        (B),
    .ops      (ops),
    .num_ops  (num_ops),
    .start_op (start_op),
    .busy     (busy),
    .end_op   (end_op),
    .result   (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  // Present a command and step past its accept edge; returns at edge+1.
  task automatic send(input logic [15:0] a, input logic [15:0] b,
                      input logic [11:0] o, input logic [2:0] n);
    A = a; B = b; ops = o; num_ops = n; start_op = 1'b1;
    @(posedge clk); #1;
    start_op = 1'b0;
  endtask

  // Edges from now until end_op is seen (0 if already high), bounded.
  task automatic wait_end(output int edges);
    edges = 0;
    while (!end_op && edges < 20) begin
      @(posedge clk); #1;
      edges++;
    end
    chk("end_op_seen", 32'(end_op), 32'd1);
  endtask

  task automatic step_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  int e;
  int pulses;

  initial begin
    rst_n = 1'b0; A = '0; B = '0; ops = '0; num_ops = '0; start_op = 1'b0;
    #2;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_end_op", 32'(end_op), 32'd0);
    chk("rst_result", result, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step_cycles(1);

    // Single ADD with carry into bit 16
    send(16'hFFFF, 16'h0001, 12'h001, 3'd1);
    chk("add_busy_after_accept", 32'(busy), 32'd1);
    chk("add_end_op_not_yet", 32'(end_op), 32'd0);
    wait_end(e);
    chk("add_latency", 32'(e), 32'd1);
    chk("add_result", result, 32'h0001_0000);
    chk("add_busy_at_end", 32'(busy), 32'd0);
    step_cycles(1);
    chk("add_end_op_drops", 32'(end_op), 32'd0);

    // Two-step chain: NOT then XOR; result must not show intermediate acc
    send(16'h00FF, 16'hFF00, 12'h037, 3'd2);
    step_cycles(1);
    chk("chain_mid_end_op", 32'(end_op), 32'd0);
    chk("chain_mid_result_held", result, 32'h0001_0000);
    wait_end(e);
    chk("chain_latency", 32'(1 + e), 32'd2);
    chk("chain_result", result, 32'h0000_FFFF);

    // MUL with an ignored start_op pulse while busy
    send(16'h1234, 16'h0010, 12'h000, 3'd1);
    A = 16'hFFFF; B = 16'hFFFF; num_ops = 3'd0; start_op = 1'b1;
    @(posedge clk); #1;
    start_op = 1'b0;
    chk("mul_busy_during", 32'(busy), 32'd1);
    wait_end(e);
    chk("mul_latency", 32'(1 + e), 32'd3);
    chk("mul_result", result, 32'h0001_2340);
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (end_op) pulses++;
    end
    chk("mul_no_extra_end_op", 32'(pulses), 32'd0);
    chk("mul_result_stable", result, 32'h0001_2340);

    // SUB wrap, then back-to-back accept in the end_op cycle
    send(16'h0001, 16'h0002, 12'h002, 3'd1);
    wait_end(e);
    chk("sub_latency", 32'(e), 32'd1);
    chk("sub_result", result, 32'hFFFF_FFFF);
    chk("sub_busy_low_in_end", 32'(busy), 32'd0);
    send(16'h0002, 16'h0003, 12'h001, 3'd1);
    chk("b2b_accepted_busy", 32'(busy), 32'd1);
    chk("b2b_end_op_dropped", 32'(end_op), 32'd0);
    wait_end(e);
    chk("b2b_latency", 32'(e), 32'd1);
    chk("b2b_result", result, 32'h0000_0005);

    // Four-step mixed chain: SUB, MUL, ADD1, NOT
    send(16'h0003, 16'h0005, 12'hEC2, 3'd4);
    wait_end(e);
    chk("mix_latency", 32'(e), 32'd6);
    chk("mix_result", result, 32'hFFFE_FFFF);

    // Reset during the second MUL_WAIT cycle
    step_cycles(1);
    send(16'h1234, 16'h0010, 12'h000, 3'd1);
    step_cycles(2);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_end_op", 32'(end_op), 32'd0);
    chk("mid_rst_result", result, 32'h0);
    step_cycles(2);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (end_op || busy) pulses++;
    end
    chk("mid_rst_no_end_op", 32'(pulses), 32'd0);
    chk("mid_rst_result_held", result, 32'h0);

    // Pass-through: completes on the accept edge itself
    send(16'hABCD, 16'h1234, 12'hFFF, 3'd0);
    chk("pass_end_op", 32'(end_op), 32'd1);
    chk("pass_busy", 32'(busy), 32'd0);
    chk("pass_result", result, 32'hABCD_1234);
    step_cycles(1);
    chk("pass_end_op_drops", 32'(end_op), 32'd0);

    // num_ops=7 saturates to 4 ADD steps
    send(16'h0000, 16'h0001, 12'h249, 3'd7);
    wait_end(e);
    chk("sat_latency", 32'(e), 32'd4);
    chk("sat_result", result, 32'h0000_0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
